// File: rtl/counter_bank_sched.sv
// ---------------------------------------------------------------------------
// counter_bank_sched
//
// Purpose:
//   Holds the 16-lane counter bank behind the text generator's data_raw bus.
//   Four update sources (global clear, host write, increment-all, per-channel
//   timer ticks) share one write port and one adder, so at most one channel
//   is written per cycle. The display sees a snapshot that is only latched
//   while the scheduler is idle, so a sweep or clear is never half visible.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   clr_req      pulse: restore every channel to its index value
//   inc_all_req  pulse: add one to every channel
//   ch_tick      per-channel increment pulses
//   wr_req       host write request, held until wr_ack
//   wr_ch        host write channel
//   wr_data      host write value
//   wr_ack       pulse in the cycle the host write commits
//   frame_start  pulse at start of vertical blanking, requests a snapshot
//   data_raw     snapshot, channel k at [k*CW +: CW]
//   snap_done    pulse the cycle after data_raw is refreshed
//   busy         high while a clear or sweep is in progress
//   ovf          sticky per-channel dropped-tick flags
// ---------------------------------------------------------------------------
module counter_bank_sched #(
    parameter int NUM_CH = 16,
    parameter int CW     = 16,
    parameter int IDX_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr_req,
    input  logic                 inc_all_req,
    input  logic [NUM_CH-1:0]    ch_tick,
    input  logic                 wr_req,
    input  logic [IDX_W-1:0]     wr_ch,
    input  logic [CW-1:0]        wr_data,
    output logic                 wr_ack,
    input  logic                 frame_start,
    output logic [NUM_CH*CW-1:0] data_raw,
    output logic                 snap_done,
    output logic                 busy,
    output logic [NUM_CH-1:0]    ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SWEEP = 2'd2
    } state_t;

    // Power-on / clear image of the bank: channel k holds the value k.
    function automatic logic [NUM_CH*CW-1:0] initVec();
        logic [NUM_CH*CW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v[k*CW +: CW] = CW'(k);
        end
        return v;
    endfunction

    localparam logic [NUM_CH*CW-1:0] INIT_VEC = initVec();
    localparam logic [IDX_W-1:0]     LAST_CH  = IDX_W'(NUM_CH - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ch_q, ch_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic                 clrPend_q, clrPend_d;
    logic                 incPend_q, incPend_d;
    logic                 snapPend_q, snapPend_d;
    logic [NUM_CH-1:0]    tickPend_q, tickPend_d;
    logic [NUM_CH-1:0]    ovf_q, ovf_d;
    logic                 snapDone_q, snapDone_d;
    logic [NUM_CH*CW-1:0] bank_q;
    logic [NUM_CH*CW-1:0] dataRaw_q;

    logic                 clrEff, snapEff, incEff;
    logic                 useClr, useSnap, useInc, wipe, snapTake;
    logic [NUM_CH-1:0]    tickClr, tickClrAll;
    logic                 wrEn;
    logic [IDX_W-1:0]     wrIdx;
    logic [CW-1:0]        wrVal;
    logic                 tickAny;
    logic [IDX_W-1:0]     tickSel, cand;

    // A request pulse counts as pending in the very cycle it arrives, so an
    // idle scheduler reacts at the next edge and simultaneous requests still
    // resolve by priority. A clear request is ignored while clearing.
    assign clrEff  = clrPend_q | (clr_req & (state_q != CLEAR));
    assign snapEff = snapPend_q | frame_start;
    assign incEff  = incPend_q | inc_all_req;

    // Round-robin tick pick: first pending channel at or after the pointer,
    // wrapping through the index width.
    always_comb begin : tickPick
        tickAny = 1'b0;
        tickSel = rr_q;
        cand    = rr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = rr_q + IDX_W'(i);
            if (!tickAny && tickPend_q[cand]) begin
                tickAny = 1'b1;
                tickSel = cand;
            end
        end
    end

    // Scheduler: chooses the single bank write for this cycle and the next
    // state. Entering CLEAR (from IDLE or by aborting a sweep) sets wipe,
    // which discards pending ticks, a pending increment-all and ovf.
    always_comb begin : arbiter
        state_d  = state_q;
        ch_d     = ch_q;
        rr_d     = rr_q;
        useClr   = 1'b0;
        useSnap  = 1'b0;
        useInc   = 1'b0;
        wipe     = 1'b0;
        snapTake = 1'b0;
        tickClr  = '0;
        wrEn     = 1'b0;
        wrIdx    = ch_q;
        wrVal    = '0;
        wr_ack   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clrEff) begin
                    state_d = CLEAR;
                    ch_d    = '0;
                    useClr  = 1'b1;
                    wipe    = 1'b1;
                end else if (snapEff) begin
                    snapTake = 1'b1;
                    useSnap  = 1'b1;
                end else if (wr_req) begin
                    wrEn           = 1'b1;
                    wrIdx          = wr_ch;
                    wrVal          = wr_data;
                    tickClr[wr_ch] = 1'b1;
                    wr_ack         = 1'b1;
                end else if (incEff) begin
                    state_d = SWEEP;
                    ch_d    = '0;
                    useInc  = 1'b1;
                end else if (tickAny) begin
                    wrEn             = 1'b1;
                    wrIdx            = tickSel;
                    wrVal            = bank_q[tickSel*CW +: CW] + CW'(1);
                    tickClr[tickSel] = 1'b1;
                    rr_d             = tickSel + IDX_W'(1);
                end
            end
            CLEAR: begin
                wrEn  = 1'b1;
                wrIdx = ch_q;
                wrVal = CW'(ch_q);
                ch_d  = ch_q + IDX_W'(1);
                if (ch_q == LAST_CH) begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (clrEff) begin
                    state_d = CLEAR;
                    ch_d    = '0;
                    useClr  = 1'b1;
                    wipe    = 1'b1;
                end else begin
                    // A tick still pending for this lane is folded into the
                    // sweep's add instead of being served separately.
                    wrEn          = 1'b1;
                    wrIdx         = ch_q;
                    wrVal         = bank_q[ch_q*CW +: CW] + CW'(1) + CW'(tickPend_q[ch_q]);
                    tickClr[ch_q] = 1'b1;
                    ch_d          = ch_q + IDX_W'(1);
                    if (ch_q == LAST_CH) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending-flag bookkeeping. A tick arriving while its lane is being
    // cleared re-arms the lane; a tick on an already pending lane that is not
    // being served is lost and recorded in ovf.
    always_comb begin : pendingNext
        tickClrAll = wipe ? {NUM_CH{1'b1}} : tickClr;
        clrPend_d  = clrEff & ~useClr;
        snapPend_d = snapEff & ~useSnap;
        incPend_d  = wipe ? inc_all_req : (incEff & ~useInc);
        ovf_d      = wipe ? '0 : (ovf_q | (ch_tick & tickPend_q & ~tickClrAll));
        tickPend_d = (tickPend_q & ~tickClrAll) | ch_tick;
        snapDone_d = snapTake;
    end

    // State, flags, bank and snapshot registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            rr_q       <= '0;
            clrPend_q  <= 1'b0;
            incPend_q  <= 1'b0;
            snapPend_q <= 1'b0;
            tickPend_q <= '0;
            ovf_q      <= '0;
            snapDone_q <= 1'b0;
            bank_q     <= INIT_VEC;
            dataRaw_q  <= INIT_VEC;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            rr_q       <= rr_d;
            clrPend_q  <= clrPend_d;
            incPend_q  <= incPend_d;
            snapPend_q <= snapPend_d;
            tickPend_q <= tickPend_d;
            ovf_q      <= ovf_d;
            snapDone_q <= snapDone_d;
            if (wrEn) begin
                bank_q[wrIdx*CW +: CW] <= wrVal;
            end
            if (snapTake) begin
                dataRaw_q <= bank_q;
            end
        end
    end

    assign data_raw  = dataRaw_q;
    assign snap_done = snapDone_q;
    assign busy      = (state_q != IDLE);
    assign ovf       = ovf_q;

endmodule
